// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit core: phase encodings, run state and
// reset-time defaults used by the sequencer and the memory interface.
package core_pkg;

  localparam logic [4:0] PH_P1 = 5'b00001;
  localparam logic [4:0] PH_P2 = 5'b00010;
  localparam logic [4:0] PH_P3 = 5'b00100;
  localparam logic [4:0] PH_P4 = 5'b01000;
  localparam logic [4:0] PH_P5 = 5'b10000;

  localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
  // Fetch (P1) and memory (P4) are the phases that may wait on memory.
  localparam logic [4:0]  DEF_WAIT_MASK = PH_P1 | PH_P4;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/phase_pc_sequencer_if.sv
// Bundle of control inputs and sequencer outputs for phase_pc_sequencer.
// The step signal exists only when SINGLE_STEP_EN is defined.
interface phase_pc_sequencer_if #(
  parameter int PHASES = 5
);
  import core_pkg::*;

  // Control inputs are level/pulse signals sampled on the rising clock edge;
  // there is no valid/ready handshake: every input is consumed every cycle.
  logic              start;
  logic              halt_inst;
  logic              mem_wait;
  logic              pc_src;
  logic [15:0]       jump;
`ifdef SINGLE_STEP_EN
  logic              step;
`endif
  logic [PHASES-1:0] phasecounter;
  logic [15:0]       pc;
  logic [15:0]       pc_plus_1;
  logic              running;
  logic              pc_we;
  logic              retired;
  run_state_t        dbg_state;

  modport master (
`ifdef SINGLE_STEP_EN
    output step,
`endif
    output start, halt_inst, mem_wait, pc_src, jump,
    input  phasecounter, pc, pc_plus_1, running, pc_we, retired, dbg_state
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    input  step,
`endif
    input  start, halt_inst, mem_wait, pc_src, jump,
    output phasecounter, pc, pc_plus_1, running, pc_we, retired, dbg_state
  );

endinterface

// File: rtl/phase_ring.sv
// One-hot phase rotator: advances one position per enabled cycle and
// synchronously resets to the first phase.
module phase_ring #(
  parameter int PHASES = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              advance,
  output logic [PHASES-1:0] phase
);

  localparam logic [PHASES-1:0] FIRST = {{(PHASES-1){1'b0}}, 1'b1};

  logic [PHASES-1:0] phase_q;
  logic [PHASES-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (advance) begin
      phase_d = {phase_q[PHASES-2:0], phase_q[PHASES-1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= FIRST;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/phase_pc_sequencer.sv
// Multicycle instruction sequencer: one-hot phase generation, PC ownership
// and run/halt control. Define SINGLE_STEP_EN to add the step input.
module phase_pc_sequencer
  import core_pkg::*;
#(
  parameter int                PHASES    = 5,
  parameter logic [15:0]       RESET_PC  = DEF_RESET_PC,
  parameter logic [PHASES-1:0] WAIT_MASK = PHASES'(DEF_WAIT_MASK)
) (
  input  logic                  clock,
  input  logic                  reset,
  phase_pc_sequencer_if.slave   bus
);

  run_state_t        state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  logic              pc_we_q, pc_we_d;
  logic              running_q, running_d;
  logic [PHASES-1:0] phase;
  logic              hold;
  logic              in_run;
  logic              advance;
  logic              end_instr;
  logic [15:0]       pc_inc;
`ifdef SINGLE_STEP_EN
  logic              budget_q, budget_d;
`endif

  assign in_run    = (state_q == RUN);
  assign hold      = (|(phase & WAIT_MASK)) & bus.mem_wait;
  assign advance   = in_run & ~hold;
  assign end_instr = advance & phase[PHASES-1];
  assign pc_inc    = pc_q + 16'd1;

  phase_ring #(.PHASES(PHASES)) u_phase_ring (
    .clock   (clock),
    .reset   (reset),
    .advance (advance),
    .phase   (phase)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_we_d = 1'b0;
`ifdef SINGLE_STEP_EN
    budget_d = budget_q;
`endif
    case (state_q)
      HALT: begin
        if (bus.start) begin
          state_d = RUN;
`ifdef SINGLE_STEP_EN
          budget_d = 1'b0;
        end else if (bus.step) begin
          state_d  = RUN;
          budget_d = 1'b1;
`endif
        end
      end
      RUN: begin
        if (end_instr) begin
          pc_d    = bus.pc_src ? bus.jump : pc_inc;
          pc_we_d = 1'b1;
          // The HLT instruction still retires, so the PC moves past it.
`ifdef SINGLE_STEP_EN
          if (bus.halt_inst || budget_q) begin
            state_d  = HALT;
            budget_d = 1'b0;
          end
`else
          if (bus.halt_inst) begin
            state_d = HALT;
          end
`endif
        end
      end
      default: state_d = HALT;
    endcase
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HALT;
      pc_q      <= RESET_PC;
      pc_we_q   <= 1'b0;
      running_q <= 1'b0;
`ifdef SINGLE_STEP_EN
      budget_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_we_q   <= pc_we_d;
      running_q <= running_d;
`ifdef SINGLE_STEP_EN
      budget_q  <= budget_d;
`endif
    end
  end

  assign bus.phasecounter = phase;
  assign bus.pc           = pc_q;
  assign bus.pc_plus_1    = pc_inc;
  assign bus.running      = running_q;
  assign bus.pc_we        = pc_we_q;
  assign bus.retired      = pc_we_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_phase_pc_sequencer.sv
// Bench for phase_pc_sequencer: directed steps followed by random stimulus,
// all checked against an instruction-level reference model.
module tb_phase_pc_sequencer;
  import core_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  phase_pc_sequencer_if #(.PHASES(5)) bus ();

  phase_pc_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: phase as an index 0..4, PC as a plain integer.
  bit          m_run;
  int          m_idx;
  int          m_pc;
  bit          m_pulse;
  bit          m_budget;
  logic [4:0]  m_mask = 5'b01001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phasecounter", 32'(bus.phasecounter), 32'(1) << m_idx);
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("pc_plus_1", 32'(bus.pc_plus_1), 32'((m_pc + 1) % 65536));
    chk("running", 32'(bus.running), 32'(m_run));
    chk("pc_we", 32'(bus.pc_we), 32'(m_pulse));
    chk("retired", 32'(bus.retired), 32'(m_pulse));
  endtask

  task automatic model_step();
    bit st;
    st = 1'b0;
`ifdef SINGLE_STEP_EN
    st = bus.step;
`endif
    m_pulse = 1'b0;
    if (reset) begin
      m_run = 0; m_idx = 0; m_pc = 0; m_budget = 0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run = 1; m_budget = 0;
      end else if (st) begin
        m_run = 1; m_budget = 1;
      end
    end else if (!(bus.mem_wait && m_mask[m_idx])) begin
      if (m_idx == 4) begin
        m_pc    = bus.pc_src ? int'(bus.jump) : (m_pc + 1) % 65536;
        m_pulse = 1;
        m_idx   = 0;
        if (bus.halt_inst || m_budget) begin
          m_run = 0; m_budget = 0;
        end
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic run_to_idx(input int idx);
    int n;
    n = 0;
    while (m_idx != idx && n < 40) begin
      tick();
      n++;
    end
    chk("run_to_idx_timeout", 32'(m_idx), 32'(idx));
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.halt_inst = 0; bus.mem_wait = 0; bus.pc_src = 0; bus.jump = 16'h0;
`ifdef SINGLE_STEP_EN
    bus.step = 0;
`endif
    m_run = 0; m_idx = 0; m_pc = 0; m_pulse = 0; m_budget = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_phase", 32'(bus.phasecounter), 32'h01);

    // Basic instruction: five phases, single retire pulse.
    bus.start = 1; tick(); bus.start = 0;
    chk("start_p1", 32'(bus.phasecounter), 32'h01);
    tick(); chk("p2", 32'(bus.phasecounter), 32'h02);
    tick(); tick(); tick();
    chk("p5", 32'(bus.phasecounter), 32'h10);
    tick();
    chk("retire_pc", 32'(bus.pc), 32'h0001);
    chk("retire_pulse", 32'(bus.retired), 32'h1);
    tick();
    chk("pulse_once", 32'(bus.pc_we), 32'h0);

    // Taken branch.
    run_to_idx(4);
    bus.pc_src = 1; bus.jump = 16'h0040; tick(); bus.pc_src = 0;
    chk("jump_pc", 32'(bus.pc), 32'h0040);

    // PC wrap.
    run_to_idx(4);
    bus.pc_src = 1; bus.jump = 16'hFFFF; tick(); bus.pc_src = 0;
    chk("pc_ffff_p1", 32'(bus.pc_plus_1), 32'h0000);
    run_to_idx(4);
    tick();
    chk("wrap_pc", 32'(bus.pc), 32'h0000);
    chk("wrap_plus1", 32'(bus.pc_plus_1), 32'h0001);

    // Memory stall in P4, ignored in P2.
    run_to_idx(3);
    bus.mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p4_held", 32'(bus.phasecounter), 32'h08);
    end
    bus.mem_wait = 0; tick();
    chk("p4_release", 32'(bus.phasecounter), 32'h10);
    run_to_idx(1);
    bus.mem_wait = 1; tick(); bus.mem_wait = 0;
    chk("p2_no_hold", 32'(bus.phasecounter), 32'h04);

    // Halt instruction at 0x0010.
    run_to_idx(4);
    bus.pc_src = 1; bus.jump = 16'h0010; tick(); bus.pc_src = 0;
    run_to_idx(4);
    bus.halt_inst = 1; tick(); bus.halt_inst = 0;
    chk("halt_pc", 32'(bus.pc), 32'h0011);
    chk("halt_running", 32'(bus.running), 32'h0);
    tick(); tick(); tick();
    chk("halt_hold_phase", 32'(bus.phasecounter), 32'h01);
    chk("halt_hold_pc", 32'(bus.pc), 32'h0011);
    bus.start = 1; tick(); bus.start = 0;
    run_to_idx(4); tick();
    chk("resume_pc", 32'(bus.pc), 32'h0012);

    // Reset mid-instruction, then reset beating start.
    run_to_idx(2);
    reset = 1; tick(); reset = 0;
    chk("midreset_pc", 32'(bus.pc), 32'h0000);
    chk("midreset_phase", 32'(bus.phasecounter), 32'h01);
    bus.start = 1; reset = 1; tick(); reset = 0; bus.start = 0;
    chk("reset_wins", 32'(bus.running), 32'h0);

`ifdef SINGLE_STEP_EN
    bus.step = 1; tick(); bus.step = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("step_pc", 32'(bus.pc), 32'h0001);
    chk("step_halted", 32'(bus.running), 32'h0);
`endif

    // Random stimulus against the model.
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      bus.start     = ($urandom_range(0, 7) == 0);
      bus.mem_wait  = ($urandom_range(0, 2) == 0);
      bus.halt_inst = ($urandom_range(0, 5) == 0);
      bus.pc_src    = $urandom_range(0, 1);
      bus.jump      = 16'($urandom);
`ifdef SINGLE_STEP_EN
      bus.step      = ($urandom_range(0, 9) == 0);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
